// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
//   Drives a 4-bit combinational ALU one nibble per clock, LSB nibble first,
//   to perform a single W-bit (W = 4*NIBBLES) operation. The carry ripples
//   between nibbles through a register. The ALU operand and control signals
//   are owned here, and the ALU output and carry are captured here.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   start            request (accepted only while busy = 0)
//   op[2:0]          010 SUB, 011 ADD, 100 AND, 101 OR, 110 XOR, 111 PASS A;
//                    000/001 are illegal
//   cin              initial carry for ADD/SUB (ignored for logic ops)
//   a, b [W-1:0]     operands, latched on accept
//   alu_a/alu_b/alu_sel/alu_cin   nibble-wide request to the ALU
//   alu_out/alu_cout              ALU response
//   busy             high from accept+1 through the done cycle
//   done             one-cycle completion pulse
//   err              illegal op flag; valid with done, held until the next accept
//   result           W-bit result; held until the next accepted start
//   carry_out, zero  final carry (ADD/SUB only) and result==0 flag
module alu_nibble_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [2:0]   alu_sel,
  output logic         alu_cin,
  input  logic [3:0]   alu_out,
  input  logic         alu_cout,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          err_q, err_d;
  logic          carry_out_q, carry_out_d;
  logic          zero_q, zero_d;
  logic          illegal_op;

  // Codes 000 and 001 are not ALU arithmetic/logic operations.
  assign illegal_op = (op[2:1] == 2'b00);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    err_d       = err_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    // The ALU sits at its quiescent values whenever no nibble is in flight.
    alu_a       = 4'd0;
    alu_b       = 4'd0;
    alu_sel     = 3'b111;
    alu_cin     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = op[2] ? 1'b0 : cin;
          err_d   = illegal_op;
          // An illegal op completes immediately and leaves result/flags untouched.
          state_d = illegal_op ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        alu_a   = a_q[{idx_q, 2'b00} +: 4];
        alu_b   = b_q[{idx_q, 2'b00} +: 4];
        alu_sel = op_q;
        // The ALU adds carry_in even for logic ops, so keep it at 0 for those.
        alu_cin = op_q[2] ? 1'b0 : carry_q;

        result_d[{idx_q, 2'b00} +: 4] = alu_out;
        carry_d = op_q[2] ? 1'b0 : alu_cout;

        if (idx_q == LAST_IDX) begin
          // Flags are captured once, from the completed result, so that they
          // remain stable through DONE and afterwards.
          carry_out_d = carry_d;
          zero_d      = (result_d == '0);
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'b111;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      err_q       <= err_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (NIBBLES = 4) wired to a behavioural 4-bit ALU.
module tb_alu_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic         cin;
  logic [W-1:0] a, b;
  logic [3:0]   alu_a, alu_b, alu_out;
  logic [2:0]   alu_sel;
  logic         alu_cin, alu_cout;
  logic         busy, done, err, carry_out, zero;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin), .a(a), .b(b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .busy(busy), .done(done), .err(err), .result(result),
    .carry_out(carry_out), .zero(zero)
  );

  // Behavioural 4-bit ALU: carry_in is added for every operation.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = 5'd0;
    case (alu_sel)
      3'b010:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
      3'b011:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
      3'b100:  alu_sum = {1'b0, alu_a & alu_b} + {4'd0, alu_cin};
      3'b101:  alu_sum = {1'b0, alu_a | alu_b} + {4'd0, alu_cin};
      3'b110:  alu_sum = {1'b0, alu_a ^ alu_b} + {4'd0, alu_cin};
      3'b111:  alu_sum = {1'b0, alu_a} + {4'd0, alu_cin};
      default: alu_sum = 5'd0;
    endcase
  end
  assign alu_out  = alu_sum[3:0];
  assign alu_cout = alu_sum[4];

  typedef struct {
    logic [2:0]   op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         e;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         e;
    int           lat;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.c   = v.c;
    e.z   = v.z;
    e.e   = v.e;
    e.lat = v.e ? 1 : NIBBLES + 1;
    return e;
  endfunction

  // Drives one request, pushes its expectation, waits for done and compares.
  // pulse_at >= 0 re-asserts start in that RUN cycle; start_in_done asserts
  // start during the done cycle (both must be ignored).
  task automatic do_txn(input int id, input logic [2:0] op_i, input logic cin_i,
                        input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input exp_t e_i, input int pulse_at, input bit start_in_done);
    int   k;
    bit   busy_bad, cin_bad, sel_bad;
    exp_t e;
    sb.push_back(e_i);
    @(negedge clk);
    start = 1'b1; op = op_i; cin = cin_i; a = a_i; b = b_i;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; busy_bad = 0; cin_bad = 0; sel_bad = 0;
    while (!done && k < 20) begin
      if (!busy) busy_bad = 1;
      if (op_i[2] && alu_cin) cin_bad = 1;
      if (alu_sel !== op_i) sel_bad = 1;
      start = (k == pulse_at);
      if (start) begin op = 3'b110; a = 16'h5555; b = 16'hAAAA; cin = 1'b1; end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk($sformatf("t%0d_done_seen", id), {31'd0, done}, 32'd1);
    chk($sformatf("t%0d_latency", id), k + 1, e.lat);
    chk($sformatf("t%0d_result", id), {16'd0, result}, {16'd0, e.res});
    chk($sformatf("t%0d_carry", id), {31'd0, carry_out}, {31'd0, e.c});
    chk($sformatf("t%0d_zero", id), {31'd0, zero}, {31'd0, e.z});
    chk($sformatf("t%0d_err", id), {31'd0, err}, {31'd0, e.e});
    chk($sformatf("t%0d_busy_run", id), {31'd0, busy_bad}, 32'd0);
    chk($sformatf("t%0d_sel_run", id), {31'd0, sel_bad}, 32'd0);
    if (op_i[2]) chk($sformatf("t%0d_cin_forced0", id), {31'd0, cin_bad}, 32'd0);
    if (start_in_done) begin
      start = 1'b1; op = 3'b011; a = 16'h0001; b = 16'h0001;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("t%0d_idle_after", id), {30'd0, busy, done}, 32'd0);
    $display("txn %0d op=%b cin=%b a=%h b=%h -> result=%h carry=%b zero=%b err=%b lat=%0d",
             id, op_i, cin_i, a_i, b_i, result, carry_out, zero, err, k + 1);
  endtask

  initial begin
    int quiet_bad;
    vec_t v;
    exp_t e;

    //          op      cin   a         b         result    c     z     e
    vecs[0]  = '{3'b011, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{3'b010, 1'b1, 16'h1234, 16'h0235, 16'h0FFF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 1'b1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b110, 1'b1, 16'hF0F0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 1'b1, 16'h1111, 16'h2222, 16'h0F0F, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'b011, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 1'b1, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{3'b111, 1'b1, 16'hABCD, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b000, 1'b0, 16'h0000, 16'h0000, 16'hABCD, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{3'b010, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{3'b011, 1'b1, 16'h7FFF, 16'h0001, 16'h8001, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 3'b000; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("rst_result_flags", {14'd0, result, carry_out, zero}, 32'd0);
    chk("rst_alu_ab", {24'd0, alu_a, alu_b}, 32'd0);
    chk("rst_alu_sel_cin", {28'd0, alu_sel, alu_cin}, 32'hE);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      do_txn(i, v.op, v.cin, v.a, v.b, mk_exp(v), -1, 1'b0);
    end

    // start pulsed during RUN and during DONE must be ignored
    e = '{res: 16'h0002, c: 1'b0, z: 1'b0, e: 1'b0, lat: NIBBLES + 1};
    do_txn(20, 3'b011, 1'b0, 16'h0001, 16'h0001, e, 1, 1'b1);
    quiet_bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy || done) quiet_bad = 1;
    end
    chk("no_queued_start", quiet_bad, 0);

    // reset during RUN nibble 2 aborts with no done pulse
    @(negedge clk);
    start = 1'b1; op = 3'b011; cin = 1'b0; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("midrst_result_flags", {14'd0, result, carry_out, zero}, 32'd0);
    chk("midrst_alu_if", {20'd0, alu_a, alu_b, alu_sel, alu_cin}, 32'h0000000E);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy || done) quiet_bad = 1;
    end
    chk("midrst_no_done", quiet_bad, 0);
    $display("reset during RUN: outputs returned to reset values");

    e = '{res: 16'h3333, c: 1'b0, z: 1'b0, e: 1'b0, lat: NIBBLES + 1};
    do_txn(21, 3'b011, 1'b0, 16'h1111, 16'h2222, e, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
